// File: rtl/sad_cs_resolve_accum_if.sv
// Bus bundle for the carry-save resolve/accumulate block: the row-beat
// input from the compressor tree and the block-SAD result output.
interface sad_cs_resolve_accum_if #(
  parameter int W_IN  = 12,
  parameter int W_OUT = 20,
  parameter int W_CNT = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  cs_sum;
  logic [W_IN-1:0]  cs_carry;
  logic             flush;
  logic             sad_valid;
  logic             sad_ready;
  logic [W_OUT-1:0] sad_out;
  logic             sad_overflow;
  logic [W_CNT-1:0] rows_out;

  // The accumulator block sits on this side of the bus.
  modport slave (
    input  in_valid, cs_sum, cs_carry, flush, sad_ready,
    output in_ready, sad_valid, sad_out, sad_overflow, rows_out
  );

  // Compressor tree / comparator side of the bus.
  modport master (
    output in_valid, cs_sum, cs_carry, flush, sad_ready,
    input  in_ready, sad_valid, sad_out, sad_overflow, rows_out
  );
endinterface

// File: rtl/sad_cs_resolve_accum.sv
// Sink of the SAD carry-save compressor tree: resolves each redundant row
// (sum + 2*carry) to binary, accumulates a block of rows with saturation,
// and hands the block SAD to the best-SAD comparator over valid/ready.
module sad_cs_resolve_accum #(
  parameter int W_IN      = 12,
  parameter int ROW_COUNT = 16,
  parameter int W_OUT     = 20,
  parameter int W_CNT     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sad_cs_resolve_accum_if.slave  bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  // Row value carries two extra bits so sum + 2*carry never truncates;
  // the adder is one bit wider than the larger operand to expose overflow.
  localparam int W_ROW = W_IN + 2;
  localparam int W_SUM = ((W_OUT > W_ROW) ? W_OUT : W_ROW) + 1;
  localparam logic [W_SUM-1:0] MAX_SUM = {{(W_SUM-W_OUT){1'b0}}, {W_OUT{1'b1}}};

  state_t           state_q, state_d;
  logic [W_OUT-1:0] acc_q, acc_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ready_q;

  logic [W_ROW-1:0] rowVal;
  logic [W_SUM-1:0] sumExt;
  logic             overRange;
  logic             accept;
  logic             holding;
  logic [W_CNT-1:0] cntInc;

  assign rowVal    = {2'b00, bus.cs_sum} + {1'b0, bus.cs_carry, 1'b0};
  assign sumExt    = {{(W_SUM-W_OUT){1'b0}}, acc_q} + {{(W_SUM-W_ROW){1'b0}}, rowVal};
  assign overRange = (sumExt > MAX_SUM);
  assign cntInc    = cnt_q + W_CNT'(1);

  // ready_q is only ever high while in ACCUM, so it alone qualifies a beat;
  // being a register it also keeps in_ready low until the first edge after reset.
  assign accept  = bus.in_valid && ready_q;
  assign holding = (state_q == HOLD);

  // Next-state logic: accumulate accepted beats, close the block on the
  // last row or a meaningful flush, and clear everything on the result handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = overRange ? {W_OUT{1'b1}} : sumExt[W_OUT-1:0];
          ovf_d = ovf_q | overRange;
          cnt_d = cntInc;
          if (cntInc == W_CNT'(ROW_COUNT)) begin
            state_d = HOLD;
          end
        end
        if (bus.flush && ((cnt_q != '0) || accept)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.sad_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial block at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d == ACCUM);
    end
  end

  // The result fields are forced to zero outside HOLD so nothing stale leaks out.
  assign bus.in_ready     = ready_q;
  assign bus.sad_valid    = holding;
  assign bus.sad_out      = holding ? acc_q : '0;
  assign bus.rows_out     = holding ? cnt_q : '0;
  assign bus.sad_overflow = holding & ovf_q;

endmodule

// File: tb/tb_sad_cs_resolve_accum.sv
// Bench for sad_cs_resolve_accum: two instances (20-bit and 16-bit result)
// driven with the same stimulus and checked every cycle against a block-level
// model built from true row sums, plus literal checks from the test plan.
module tb_sad_cs_resolve_accum;

  localparam int  W_IN      = 12;
  localparam int  ROW_COUNT = 16;
  localparam int  W_CNT     = 5;
  localparam longint MAX_A  = (64'd1 << 20) - 1;
  localparam longint MAX_B  = (64'd1 << 16) - 1;

  logic            clk;
  logic            rst_n;
  logic            inValid;
  logic [W_IN-1:0] csSum;
  logic [W_IN-1:0] csCarry;
  logic            flushIn;
  logic            sadReady;

  int vectors;
  int miscompares;

  // Model state: true (unsaturated) sum of the open block, its row count,
  // whether a result is being presented, and whether an edge has occurred since reset.
  longint mSum;
  int     mRows;
  bit     mHold;
  bit     rstSeen;

  sad_cs_resolve_accum_if #(.W_IN(W_IN), .W_OUT(20), .W_CNT(W_CNT)) ifA ();
  sad_cs_resolve_accum_if #(.W_IN(W_IN), .W_OUT(16), .W_CNT(W_CNT)) ifB ();

  assign ifA.in_valid  = inValid;
  assign ifA.cs_sum    = csSum;
  assign ifA.cs_carry  = csCarry;
  assign ifA.flush     = flushIn;
  assign ifA.sad_ready = sadReady;
  assign ifB.in_valid  = inValid;
  assign ifB.cs_sum    = csSum;
  assign ifB.cs_carry  = csCarry;
  assign ifB.flush     = flushIn;
  assign ifB.sad_ready = sadReady;

  sad_cs_resolve_accum #(.W_IN(W_IN), .ROW_COUNT(ROW_COUNT), .W_OUT(20), .W_CNT(W_CNT)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA)
  );

  sad_cs_resolve_accum #(.W_IN(W_IN), .ROW_COUNT(ROW_COUNT), .W_OUT(16), .W_CNT(W_CNT)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, hold them across the next rising edge, return just after it.
  task automatic applyStimulus(input bit v, input logic [W_IN-1:0] s, input logic [W_IN-1:0] c, input bit f);
    inValid = v;
    csSum   = s;
    csCarry = c;
    flushIn = f;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    inValid = 1'b0;
    csSum   = '0;
    csCarry = '0;
    flushIn = 1'b0;
  endtask

  task automatic sendBeats(input int n, input logic [W_IN-1:0] s, input logic [W_IN-1:0] c);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, s, c, 1'b0);
    end
    setIdle();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the block model, then advance the model by
  // the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    bit     expReady;
    bit     accept;
    longint expA;
    longint expB;
    if (!rst_n) begin
      checkOutput("rst_in_ready_A", ifA.in_ready, 0);
      checkOutput("rst_sad_valid_A", ifA.sad_valid, 0);
      checkOutput("rst_sad_out_A", ifA.sad_out, 0);
      checkOutput("rst_rows_out_A", ifA.rows_out, 0);
      checkOutput("rst_overflow_A", ifA.sad_overflow, 0);
      checkOutput("rst_sad_out_B", ifB.sad_out, 0);
      mSum    = 0;
      mRows   = 0;
      mHold   = 1'b0;
      rstSeen = 1'b0;
    end else begin
      expReady = rstSeen && !mHold;
      checkOutput("in_ready_A", ifA.in_ready, expReady);
      checkOutput("in_ready_B", ifB.in_ready, expReady);
      checkOutput("sad_valid_A", ifA.sad_valid, mHold);
      checkOutput("sad_valid_B", ifB.sad_valid, mHold);
      if (mHold) begin
        expA = (mSum > MAX_A) ? MAX_A : mSum;
        expB = (mSum > MAX_B) ? MAX_B : mSum;
        checkOutput("sad_out_A", ifA.sad_out, expA);
        checkOutput("sad_out_B", ifB.sad_out, expB);
        checkOutput("overflow_A", ifA.sad_overflow, (mSum > MAX_A) ? 1 : 0);
        checkOutput("overflow_B", ifB.sad_overflow, (mSum > MAX_B) ? 1 : 0);
        checkOutput("rows_out_A", ifA.rows_out, mRows);
        checkOutput("rows_out_B", ifB.rows_out, mRows);
        if (sadReady) begin
          mHold = 1'b0;
          mSum  = 0;
          mRows = 0;
        end
      end else begin
        accept = inValid && expReady;
        if (accept) begin
          mSum  = mSum + longint'(csSum) + 2 * longint'(csCarry);
          mRows = mRows + 1;
        end
        if ((accept && mRows == ROW_COUNT) || (flushIn && mRows > 0)) begin
          mHold = 1'b1;
        end
      end
      rstSeen = 1'b1;
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    mSum        = 0;
    mRows       = 0;
    mHold       = 1'b0;
    rstSeen     = 1'b0;
    rst_n       = 1'b0;
    sadReady    = 1'b1;
    setIdle();

    // Reset state, then release and confirm in_ready comes up.
    @(negedge clk);
    checkOutput("reset_in_ready", ifA.in_ready, 0);
    checkOutput("reset_sad_out", ifA.sad_out, 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("ready_after_release", ifA.in_ready, 1);

    // Test 1: 16 beats of row=16 with downstream always ready.
    $display("[TB] test 1: full block, sad_ready=1");
    sendBeats(16, 12'h00A, 12'h003);
    @(negedge clk);
    checkOutput("t1_sad_valid", ifA.sad_valid, 1);
    checkOutput("t1_sad_out", ifA.sad_out, 'h00100);
    checkOutput("t1_rows_out", ifA.rows_out, 16);
    checkOutput("t1_overflow", ifA.sad_overflow, 0);
    checkOutput("t1_in_ready_low", ifA.in_ready, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_in_ready_back", ifA.in_ready, 1);
    checkOutput("t1_valid_dropped", ifA.sad_valid, 0);
    nextCycle();

    // Test 2: result held under back-pressure, then accumulator cleared.
    $display("[TB] test 2: back-pressure and accumulator clear");
    sadReady = 1'b0;
    sendBeats(16, 12'h00A, 12'h003);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t2_hold_sad_out", ifA.sad_out, 'h00100);
      checkOutput("t2_hold_in_ready", ifA.in_ready, 0);
      nextCycle();
    end
    sadReady = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    sendBeats(16, 12'h001, 12'h000);
    @(negedge clk);
    checkOutput("t2_second_block", ifA.sad_out, 'h00010);
    nextCycle();

    // Test 3: saturation on the 16-bit instance, then a clean block.
    $display("[TB] test 3: saturation and overflow clear");
    sendBeats(16, 12'hFFF, 12'hFFF);
    @(negedge clk);
    checkOutput("t3_sat_out_B", ifB.sad_out, 'hFFFF);
    checkOutput("t3_sat_ovf_B", ifB.sad_overflow, 1);
    checkOutput("t3_wide_out_A", ifA.sad_out, 196560);
    checkOutput("t3_wide_ovf_A", ifA.sad_overflow, 0);
    nextCycle();
    sendBeats(16, 12'h001, 12'h000);
    @(negedge clk);
    checkOutput("t3_after_out_B", ifB.sad_out, 'h0010);
    checkOutput("t3_after_ovf_B", ifB.sad_overflow, 0);
    nextCycle();

    // Test 4: flush after beats, flush with the last beat, flush on an empty block.
    $display("[TB] test 4: flush");
    sendBeats(3, 12'h00A, 12'h003);
    applyStimulus(1'b0, '0, '0, 1'b1);
    setIdle();
    @(negedge clk);
    checkOutput("t4_flush_out", ifA.sad_out, 48);
    checkOutput("t4_flush_rows", ifA.rows_out, 3);
    nextCycle();
    sendBeats(2, 12'h00A, 12'h003);
    applyStimulus(1'b1, 12'h00A, 12'h003, 1'b1);
    setIdle();
    @(negedge clk);
    checkOutput("t4_same_cycle_valid", ifA.sad_valid, 1);
    checkOutput("t4_same_cycle_out", ifA.sad_out, 48);
    checkOutput("t4_same_cycle_rows", ifA.rows_out, 3);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    setIdle();
    @(negedge clk);
    checkOutput("t4_empty_flush", ifA.sad_valid, 0);
    nextCycle();

    // Test 5: reset in the middle of a block.
    $display("[TB] test 5: reset mid-block");
    sendBeats(7, 12'h00A, 12'h003);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t5_async_ready", ifA.in_ready, 0);
    checkOutput("t5_async_valid", ifA.sad_valid, 0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    sendBeats(16, 12'h001, 12'h000);
    @(negedge clk);
    checkOutput("t5_post_reset_out", ifA.sad_out, 16);
    checkOutput("t5_post_reset_rows", ifA.rows_out, 16);
    nextCycle();

    // Test 6: gaps with garbage on the data inputs between beats.
    $display("[TB] test 6: gapped beats with junk data");
    for (int b = 0; b < 16; b++) begin
      applyStimulus(1'b1, 12'h00A, 12'h003, 1'b0);
      if (b < 15) begin
        repeat ($urandom_range(1, 4)) applyStimulus(1'b0, 12'($urandom), 12'($urandom), 1'b0);
      end
    end
    setIdle();
    @(negedge clk);
    checkOutput("t6_gap_out", ifA.sad_out, 'h00100);
    checkOutput("t6_no_x", $isunknown({ifA.sad_out, ifA.rows_out, ifA.sad_overflow, ifA.sad_valid, ifA.in_ready}) ? 1 : 0, 0);
    nextCycle();

    // Randomized traffic: valid, data, flush, back-pressure and occasional reset.
    $display("[TB] random phase");
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      sadReady = ($urandom_range(0, 9) < 6);
      applyStimulus(($urandom_range(0, 9) < 7), 12'($urandom), 12'($urandom), ($urandom_range(0, 19) == 0));
    end
    rst_n    = 1'b1;
    sadReady = 1'b1;
    setIdle();
    repeat (4) nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
